// File: rtl/load_store_unit.sv
// Load/store unit: 32-bit word-addressed data memory port with byte/half/word
// access, sign/zero extension and read-modify-write for sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with resp_err.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        misalign;
    logic        err;
    logic        sub_store;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [31:0] word_addr;

    assign accept    = req_valid && req_ready;
    assign word_addr = {addr_q[31:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((size_q == SIZE_HALF) && addr_q[0]) ||
                      ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign err       = (size_q == 2'b11) || misalign;
    assign sub_store = we_q && !err && ((size_q == SIZE_BYTE) || (size_q == SIZE_HALF));

    // Lane extraction and extension for loads (little-endian lanes).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        byte_sel = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SIZE_BYTE: load_ext = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_ext = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            SIZE_WORD: load_ext = mem_rdata;
            default:   load_ext = 32'h0;
        endcase
    end

    // Replace the target lane of the captured word for sub-word stores.
    always_comb begin
        merged = word_q;
        if (size_q == SIZE_BYTE) begin
            case (addr_q[1:0])
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                2'd3:    merged[31:24] = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = sub_store ? MERGE : RESP;
            MERGE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
            if (state_q == ACCESS) begin
                if (sub_store) word_q <= mem_rdata;
                rdata_q <= (!we_q && !err) ? load_ext : 32'h0;
            end
        end
    end

    // req_ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        case (state_q)
            IDLE:   req_ready = rst_n;
            ACCESS: begin
                mem_addr = word_addr;
                if (we_q && !err && (size_q == SIZE_WORD)) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                end
            end
            MERGE: begin
                mem_addr  = word_addr;
                mem_we    = 1'b1;
                mem_wdata = merged;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word/byte/half loads and stores against a
// small word memory model, latency, illegal size, misalignment and mid-op reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] res_rdata;
    logic        res_err;
    int          res_lat;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] we_data;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, then follow it to RESP.
    task automatic txn(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_addr     = addr ^ 32'h0000_0007;
        req_wdata    = ~wdata;
        n       = 0;
        we_cnt  = 0;
        we_cyc  = -1;
        we_data = 32'h0;
        while (n < 8) begin
            if (mem_we) begin
                we_cnt++;
                we_cyc  = n;
                we_data = mem_wdata;
            end
            if (resp_valid) break;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " resp_seen"}, {31'h0, resp_valid}, 32'h1);
        check({name, " ready_in_resp"}, {31'h0, req_ready}, 32'h0);
        res_rdata = resp_rdata;
        res_err   = resp_err;
        res_lat   = n + 1;
        @(posedge clk);
        #1;
        check({name, " idle_ready"}, {31'h0, req_ready}, 32'h1);
        check({name, " idle_addr"}, mem_addr, 32'h0);
        check({name, " idle_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic load_chk(input string name, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic exp_err);
        txn(name, 1'b0, size, uns, addr, 32'hA5A5_A5A5);
        check({name, " rdata"}, res_rdata, exp_data);
        check({name, " err"}, {31'h0, res_err}, {31'h0, exp_err});
        check({name, " lat"}, res_lat, 2);
        check({name, " no_we"}, we_cnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", {31'h0, req_ready}, 32'h0);
        check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err", {31'h0, resp_err}, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst ready", {31'h0, req_ready}, 32'h1);

        // Word store then word load
        txn("sw8", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
        check("sw8 lat", res_lat, 2);
        check("sw8 err", {31'h0, res_err}, 32'h0);
        check("sw8 rdata", res_rdata, 32'h0);
        check("sw8 we_cnt", we_cnt, 1);
        check("sw8 we_cyc", we_cyc, 0);
        check("sw8 wdata", we_data, 32'hDEAD_BEEF);
        check("sw8 mem", mem[2], 32'hDEAD_BEEF);
        load_chk("lw8", 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b0);

        // Byte store read-modify-write: write only in MERGE
        txn("sb9", 1'b1, 2'b00, 1'b0, 32'h9, 32'hABCD_EF55);
        check("sb9 lat", res_lat, 3);
        check("sb9 we_cnt", we_cnt, 1);
        check("sb9 we_cyc", we_cyc, 1);
        check("sb9 wdata", we_data, 32'hDEAD_55EF);
        check("sb9 mem", mem[2], 32'hDEAD_55EF);

        // Sub-word loads with sign/zero extension
        load_chk("lb_b", 2'b00, 1'b0, 32'hB, 32'hFFFF_FFDE, 1'b0);
        load_chk("lbu_b", 2'b00, 1'b1, 32'hB, 32'h0000_00DE, 1'b0);
        load_chk("lh_a", 2'b01, 1'b0, 32'hA, 32'hFFFF_DEAD, 1'b0);
        load_chk("lhu_8", 2'b01, 1'b1, 32'h8, 32'h0000_55EF, 1'b0);
`ifdef MISALIGN_TRAP_EN
        load_chk("lh_9", 2'b01, 1'b0, 32'h9, 32'h0, 1'b1);
`else
        load_chk("lh_9", 2'b01, 1'b0, 32'h9, 32'h0000_55EF, 1'b0);
`endif

        // Upper halfword store, then signed byte load from lane 0
        txn("sh_a", 1'b1, 2'b01, 1'b0, 32'hA, 32'h7777_1234);
        check("sh_a lat", res_lat, 3);
        check("sh_a wdata", we_data, 32'h1234_55EF);
        check("sh_a mem", mem[2], 32'h1234_55EF);
        load_chk("lb_8", 2'b00, 1'b0, 32'h8, 32'hFFFF_FFEF, 1'b0);
        load_chk("lhu_a", 2'b01, 1'b1, 32'hA, 32'h0000_1234, 1'b0);

        // Illegal size: error, no write, 2-cycle latency
        txn("ill", 1'b1, 2'b11, 1'b0, 32'h8, 32'h0);
        check("ill err", {31'h0, res_err}, 32'h1);
        check("ill rdata", res_rdata, 32'h0);
        check("ill lat", res_lat, 2);
        check("ill we_cnt", we_cnt, 0);
        check("ill mem", mem[2], 32'h1234_55EF);

        // Misaligned word store
        txn("sw6", 1'b1, 2'b10, 1'b0, 32'h6, 32'hCAFE_F00D);
        check("sw6 lat", res_lat, 2);
`ifdef MISALIGN_TRAP_EN
        check("sw6 err", {31'h0, res_err}, 32'h1);
        check("sw6 we_cnt", we_cnt, 0);
        check("sw6 mem", mem[1], 32'h0);
        load_chk("lw4", 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
`else
        check("sw6 err", {31'h0, res_err}, 32'h0);
        check("sw6 we_cnt", we_cnt, 1);
        check("sw6 mem", mem[1], 32'hCAFE_F00D);
        load_chk("lw4", 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D, 1'b0);
`endif

        // Reset pulsed during MERGE of a byte store
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h8;
        req_wdata    = 32'h0000_00AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmw access_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        #1;
        check("rmw merge_we", {31'h0, mem_we}, 32'h1);
        check("rmw merge_wdata", mem_wdata, 32'h1234_55AA);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort mem_we", {31'h0, mem_we}, 32'h0);
        check("abort mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        check("abort ready", {31'h0, req_ready}, 32'h0);
        check("abort resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("release mem_we", {31'h0, mem_we}, 32'h0);
        check("release mem", mem[2], 32'h1234_55EF);
        load_chk("lw8_after", 2'b10, 1'b0, 32'h8, 32'h1234_55EF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
